// File: rtl/ddr_write_sequencer.sv
// DDR write command sequencer: ACT / WRITE / PRE with tRCD, tWR, tRP spacing.
// Periodic AUTO REFRESH is built only when DDR_SEQ_REFRESH_EN is defined.
module ddr_write_sequencer #(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BA_W      = 2,
  parameter int BURST_LEN = 8,
  parameter int T_RCD     = 2,
  parameter int T_WR      = 3,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 10,
  parameter int T_REFI    = 780
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init_done,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [BA_W+ROW_W+COL_W-1:0]  req_addr,
  output logic                         wren,
  output logic [3:0]                   cmd_state,
  output logic                         busy,
  output logic                         ddr_cs_n,
  output logic                         ddr_ras_n,
  output logic                         ddr_cas_n,
  output logic                         ddr_we_n,
  output logic [BA_W-1:0]              ddr_ba,
  output logic [ROW_W-1:0]             ddr_a
);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    ACTIVE       = 4'd1,
    WAIT_TRCD    = 4'd2,
    WRITE        = 4'd3,
    WAIT_BURST   = 4'd4,
    WAIT_TWR     = 4'd5,
    PRECHARGE    = 4'd6,
    WAIT_TRP     = 4'd7,
    AUTO_REFRESH = 4'd8,
    WAIT_TRFC    = 4'd9
  } state_t;

  localparam int CNT_W = 16;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BA_W-1:0]    bank_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   col_a;
  logic [ROW_W-1:0]   pre_a;
  logic               pending;
  logic               pend_nx;

  logic [BA_W-1:0]    req_bank;
  logic [ROW_W-1:0]   req_row;
  logic [COL_W-1:0]   req_col;

  assign req_bank  = req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
  assign req_row   = req_addr[ROW_W+COL_W-1 -: ROW_W];
  assign req_col   = req_addr[COL_W-1:0];
  assign cmd_state = state;
  assign ddr_cs_n  = 1'b0;

  // a[10] selects auto-precharge on WRITE and all-banks on PRECHARGE
  always_comb begin
    col_a     = ROW_W'(col_q);
    col_a[10] = 1'b0;
    pre_a     = '0;
    pre_a[10] = 1'b1;
  end

`ifdef DDR_SEQ_REFRESH_EN
  localparam int REF_W = $clog2(T_REFI + 1);

  logic [REF_W-1:0] ref_cnt;
  logic             wrap;

  assign wrap = init_done && (ref_cnt == REF_W'(T_REFI - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
    end else if (!init_done || wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // leaving IDLE with pending set means entering AUTO_REFRESH
  assign pend_nx = wrap || (pending && (state != IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else begin
      pending <= pend_nx;
    end
  end
`else
  logic unused_cfg;

  assign pending    = 1'b0;
  assign pend_nx    = 1'b0;
  assign unused_cfg = (T_REFI > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      wren      <= 1'b0;
      busy      <= 1'b0;
      ddr_ras_n <= 1'b1;
      ddr_cas_n <= 1'b1;
      ddr_we_n  <= 1'b1;
      ddr_ba    <= '0;
      ddr_a     <= '0;
      bank_q    <= '0;
      col_q     <= '0;
    end else begin
      ddr_ras_n <= 1'b1;
      ddr_cas_n <= 1'b1;
      ddr_we_n  <= 1'b1;
      wren      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pending) begin
            state     <= AUTO_REFRESH;
            ddr_ras_n <= 1'b0;
            ddr_cas_n <= 1'b0;
          end else if (req_valid && req_ready) begin
            state     <= ACTIVE;
            ddr_ras_n <= 1'b0;
            ddr_ba    <= req_bank;
            ddr_a     <= req_row;
            bank_q    <= req_bank;
            col_q     <= req_col;
          end else begin
            busy      <= 1'b0;
            req_ready <= init_done && !pend_nx;
          end
        end
        ACTIVE: begin
          state <= WAIT_TRCD;
          cnt   <= CNT_W'(T_RCD - 2);
        end
        WAIT_TRCD: begin
          if (cnt == '0) begin
            state     <= WRITE;
            ddr_cas_n <= 1'b0;
            ddr_we_n  <= 1'b0;
            ddr_ba    <= bank_q;
            ddr_a     <= col_a;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          state <= WAIT_BURST;
          cnt   <= CNT_W'(BURST_LEN / 2 - 1);
          wren  <= 1'b1;
        end
        WAIT_BURST: begin
          if (cnt == '0) begin
            state <= WAIT_TWR;
            cnt   <= CNT_W'(T_WR - 1);
          end else begin
            cnt  <= cnt - CNT_W'(1);
            wren <= 1'b1;
          end
        end
        WAIT_TWR: begin
          if (cnt == '0) begin
            state     <= PRECHARGE;
            ddr_ras_n <= 1'b0;
            ddr_we_n  <= 1'b0;
            ddr_a     <= pre_a;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PRECHARGE: begin
          state <= WAIT_TRP;
          cnt   <= CNT_W'(T_RP - 2);
        end
        WAIT_TRP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= init_done && !pend_nx;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        AUTO_REFRESH: begin
          state <= WAIT_TRFC;
          cnt   <= CNT_W'(T_RFC - 2);
        end
        WAIT_TRFC: begin
          if (cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= init_done && !pend_nx;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_write_sequencer.sv
// Scoreboard bench for ddr_write_sequencer: directed writes, init gating,
// reset abort and (with DDR_SEQ_REFRESH_EN) refresh interleaving.
module tb_ddr_write_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_done = 1'b0;
  logic        req_valid = 1'b0;
  logic [24:0] req_addr = '0;
  logic        req_ready;
  logic        wren;
  logic [3:0]  cmd_state;
  logic        busy;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] a;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int wren_total = 0;
  int ref_cnt = 0;
  int trfc_left = 0;
  int ref_cyc[$];

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic        wr;
    logic        chk_ba;
    logic        chk_a;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [3:0]  st;
  } exp_t;

  exp_t exp_q[$];

  logic [1:0]  vba[4]  = '{2'd2, 2'd3, 2'd0, 2'd1};
  logic [12:0] vrow[4] = '{13'h0155, 13'h1FFF, 13'h0000, 13'h0AAA};
  logic [9:0]  vcol[4] = '{10'h03C, 10'h3FF, 10'h000, 10'h155};
  logic [12:0] vwra[4] = '{13'h003C, 13'h03FF, 13'h0000, 13'h0155};

  ddr_write_sequencer #(.T_REFI(40)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .wren      (wren),
    .cmd_state (cmd_state),
    .busy      (busy),
    .ddr_cs_n  (cs_n),
    .ddr_ras_n (ras_n),
    .ddr_cas_n (cas_n),
    .ddr_we_n  (we_n),
    .ddr_ba    (ba),
    .ddr_a     (a)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input int c, input logic [2:0] cmd,
                              input logic wr, input logic cb,
                              input logic ca, input logic [1:0] eba,
                              input logic [12:0] ea, input logic [3:0] st);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.wr = wr; e.chk_ba = cb;
    e.chk_a = ca; e.ba = eba; e.a = ea; e.st = st;
    return e;
  endfunction

  // monitor: every non-NOP command or wren cycle is popped and compared
  logic [2:0] m_c;
  exp_t       m_e;
  logic       m_ok;
  always @(negedge clk) begin
    m_c = {ras_n, cas_n, we_n};
    if (rst) begin
      if (wren) wren_total++;
`ifdef DDR_SEQ_REFRESH_EN
      if (m_c == 3'b001) begin
        tests++;
        ref_cnt++;
        ref_cyc.push_back(cyc);
        trfc_left = 9;
        if (cmd_state != 4'd8 || req_ready || wren || cs_n) begin
          errors++;
          $display("FAIL ref_cmd cyc=%0d: st=%0d rdy=%b wren=%b, required st=8 rdy=0 wren=0",
                   cyc, cmd_state, req_ready, wren);
        end
      end else if (trfc_left > 0) begin
        tests++;
        trfc_left--;
        if (cmd_state != 4'd9 || req_ready || m_c != 3'b111) begin
          errors++;
          $display("FAIL trfc cyc=%0d: st=%0d rdy=%b cmd=%b, required st=9 rdy=0 cmd=111",
                   cyc, cmd_state, req_ready, m_c);
        end
      end else
`endif
      if (m_c != 3'b111 || wren) begin
        tests++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: cmd=%b wren=%b st=%0d, required none",
                   cyc, m_c, wren, cmd_state);
        end else begin
          m_e = exp_q.pop_front();
          m_ok = (m_e.cyc == cyc) && (m_e.cmd == m_c) && (m_e.wr == wren) &&
                 (m_e.st == cmd_state) && !cs_n &&
                 (!m_e.chk_ba || m_e.ba == ba) && (!m_e.chk_a || m_e.a == a);
          if (!m_ok) begin
            errors++;
            $display("FAIL event: got cyc=%0d cmd=%b wren=%b st=%0d ba=%0d a=%h cs_n=%b, required cyc=%0d cmd=%b wren=%b st=%0d ba=%0d a=%h",
                     cyc, m_c, wren, cmd_state, ba, a, cs_n,
                     m_e.cyc, m_e.cmd, m_e.wr, m_e.st, m_e.ba, m_e.a);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // present vector v; once accepted, push the full expected command train
  task automatic issue(input int v, input bit drop, output int b);
    int n;
    n = 0;
    req_addr  = {vba[v], vrow[v], vcol[v]};
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    b = cyc;
    if (!req_ready) begin
      tests++;
      errors++;
      $display("FAIL handshake_timeout: got req_ready=0, required 1 within 200 cycles");
    end else begin
      exp_q.push_back(mk(b + 1, 3'b011, 1'b0, 1'b1, 1'b1, vba[v], vrow[v], 4'd1));
      exp_q.push_back(mk(b + 3, 3'b100, 1'b0, 1'b1, 1'b1, vba[v], vwra[v], 4'd3));
      for (int i = 4; i <= 7; i++)
        exp_q.push_back(mk(b + i, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 4'd4));
      exp_q.push_back(mk(b + 11, 3'b010, 1'b0, 1'b0, 1'b1, 2'd0, 13'h0400, 4'd6));
    end
    tick();
    if (drop) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int b1, b2, w0, n;
`ifdef DDR_SEQ_REFRESH_EN
    int r0, rr;
`endif
    repeat (2) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_wren", wren, 0);
    chk("rst_state", cmd_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", {cs_n, ras_n, cas_n, we_n}, 4'b0111);
    chk("rst_ba", ba, 0);
    chk("rst_a", a, 0);
    rst = 1'b1;

    req_addr  = {vba[3], vrow[3], vcol[3]};
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("noinit_ready", req_ready, 0);
    end
    init_done = 1'b1;
    issue(3, 1'b1, b1);
    drain();

    issue(0, 1'b1, b1);
`ifndef DDR_SEQ_REFRESH_EN
    while (cyc < b1 + 12) tick();
    chk("c12_state", cmd_state, 7);
    chk("c12_ready", req_ready, 0);
    tick();
    chk("c13_state", cmd_state, 0);
    chk("c13_ready", req_ready, 1);
`endif
    drain();

    w0 = wren_total;
    issue(1, 1'b0, b1);
    issue(2, 1'b1, b2);
`ifndef DDR_SEQ_REFRESH_EN
    chk("b2b_gap", b2 - b1, 13);
`endif
    drain();
    chk("b2b_wren", wren_total - w0, 8);

    issue(0, 1'b1, b1);
    n = 0;
    while (!wren && n < 20) begin
      tick();
      n++;
    end
    chk("abort_wren_seen", wren, 1);
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("abort_wren", wren, 0);
    chk("abort_state", cmd_state, 0);
    chk("abort_cmd", {cs_n, ras_n, cas_n, we_n}, 4'b0111);
    chk("abort_ready", req_ready, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b1;
    n = 0;
    while (!req_ready && n < 5) begin
      tick();
      n++;
    end
    chk("abort_ready_back", req_ready, 1);

`ifdef DDR_SEQ_REFRESH_EN
    r0 = ref_cnt;
    n = 0;
    while (ref_cnt < r0 + 3 && n < 200) begin
      tick();
      n++;
    end
    chk("ref_count", ref_cnt - r0, 3);
    if (ref_cyc.size() >= 2) begin
      chk("ref_period", ref_cyc[ref_cyc.size()-1] - ref_cyc[ref_cyc.size()-2], 40);
      rr = ref_cyc[ref_cyc.size()-1];
      while (cyc < rr + 33) tick();
      issue(0, 1'b0, b1);
      issue(1, 1'b1, b2);
      chk("ref_after_write", ref_cyc[ref_cyc.size()-1], b1 + 14);
      chk("req_after_trfc", b2 - b1, 24);
      drain();
    end
`endif

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
